// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//
// Instruction-fetch stage feeding the IF/ID register. Owns the fetch PC,
// issues in-order word requests to instruction memory under a credit limit
// of DEPTH, and buffers returned instructions with their PCs in a FIFO so
// decode stalls are absorbed without re-fetching. A taken redirect flushes
// the FIFO and discards every response still in flight.
//
// Ports:
//   clk, rst         pipeline clock; synchronous active-high reset
//   redirect_valid   taken jump/branch this cycle
//   redirect_pc      new fetch target (bits [1:0] ignored)
//   imem_req_valid   fetch request valid
//   imem_req_addr    word-aligned fetch address
//   imem_req_ready   memory accepts the request this cycle
//   imem_rsp_valid   instruction returned, in request order
//   imem_rsp_data    returned instruction
//   out_valid        FIFO head valid
//   out_instr        head instruction
//   out_pc           head PC
//   out_ready        decode accepts the head
//   occupancy        number of valid FIFO entries
//
// Build option:
//   IFQ_BYPASS_EN    when defined, a live response arriving at an empty FIFO
//                    is presented at the head combinationally in the same
//                    cycle (and not written if consumed). When undefined the
//                    head is purely registered.
// ----------------------------------------------------------------------------
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  typedef enum logic {RUN, FLUSHING} state_t;

  state_t          state, state_next;
  logic            rst_q;
  logic [31:0]     fetch_pc;
  logic [CW-1:0]   count, inflight, drop_cnt, drop_next, outstanding;
  logic [AW-1:0]   rd_ptr, wr_ptr, tag_rd_ptr, tag_wr_ptr;
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     tag_mem   [DEPTH];
  logic [31:0]     hold_instr, hold_pc;
  logic [CW+1:0]   credit_used;
  logic            req_fire, rsp_live, rsp_drop, head_valid, pop, push, bypass_hit;

  // Every request slot is reserved until its response is either buffered or
  // dropped, so the FIFO can never overflow.
  assign credit_used    = {2'b00, count} + {2'b00, inflight} + {2'b00, drop_cnt};
  assign imem_req_valid = !rst_q && (credit_used < DEPTH_W) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses belonging to a flushed stream are consumed by drop_cnt first;
  // a response with nothing outstanding is ignored.
  assign rsp_drop    = imem_rsp_valid && !redirect_valid && (drop_cnt != '0);
  assign rsp_live    = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && (inflight != '0);
  assign outstanding = drop_cnt + inflight;

  assign head_valid = (count != '0);
  assign pop        = head_valid && out_ready;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = rsp_live && !head_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed response that decode takes immediately never enters the FIFO.
  assign push      = rsp_live && !(bypass_hit && out_ready);
  assign occupancy = count;

  // NOTE: every signal driven in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    out_valid = head_valid;
    out_instr = head_valid ? instr_mem[rd_ptr] : hold_instr;
    out_pc    = head_valid ? pc_mem[rd_ptr]    : hold_pc;
    if (bypass_hit) begin
      out_valid = 1'b1;
      out_instr = imem_rsp_data;
      out_pc    = tag_mem[tag_rd_ptr];
    end
  end

  // On redirect every outstanding response becomes one to drop, less the one
  // arriving (and discarded) in the redirect cycle itself.
  always_comb begin
    drop_next = drop_cnt;
    if (redirect_valid) begin
      drop_next = outstanding;
      if (imem_rsp_valid && (outstanding != '0)) drop_next = outstanding - CW'(1);
    end else if (rsp_drop) begin
      drop_next = drop_cnt - CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (redirect_valid && (drop_next != '0)) state_next = FLUSHING;
      FLUSHING: if (drop_next == '0) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q      <= 1'b1;
      fetch_pc   <= RESET_PC;
      count      <= '0;
      inflight   <= '0;
      drop_cnt   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      tag_rd_ptr <= '0;
      tag_wr_ptr <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      rst_q    <= 1'b0;
      drop_cnt <= drop_next;
      // Remember what the head showed so an empty FIFO keeps presenting it.
      if (out_valid) begin
        hold_instr <= out_instr;
        hold_pc    <= out_pc;
      end
      if (redirect_valid) begin
        fetch_pc   <= redirect_pc & ~32'h3;
        count      <= '0;
        inflight   <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        tag_rd_ptr <= '0;
        tag_wr_ptr <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc   <= fetch_pc + 32'd4;
          tag_wr_ptr <= tag_wr_ptr + AW'(1);
        end
        if (rsp_live) tag_rd_ptr <= tag_rd_ptr + AW'(1);
        if (push)     wr_ptr     <= wr_ptr + AW'(1);
        if (pop)      rd_ptr     <= rd_ptr + AW'(1);
        count    <= count + CW'(push) - CW'(pop);
        inflight <= inflight + CW'(req_fire) - CW'(rsp_live);
      end
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers
  // and counters, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_ptr] <= fetch_pc;
    if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= tag_mem[tag_rd_ptr];
    end
  end

  // Memory must never return a response that was not requested.
  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
//
// Random-stimulus bench for ifetch_queue (default build). A memory model
// accepts requests and returns responses in order after a random latency.
// The reference model tracks the expected fetch address stream and, for each
// live response, pushes the expected {pc, instr} into a scoreboard; the
// monitor pops it whenever decode takes the head.
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   redirect_valid = 1'b0;
  logic [31:0]            redirect_pc = '0;
  logic                   imem_req_valid;
  logic [31:0]            imem_req_addr;
  logic                   imem_req_ready = 1'b0;
  logic                   imem_rsp_valid = 1'b0;
  logic [31:0]            imem_rsp_data = '0;
  logic                   out_valid;
  logic [31:0]            out_instr;
  logic [31:0]            out_pc;
  logic                   out_ready = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          epoch;
    int          due;
  } mem_txn_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } out_txn_t;

  mem_txn_t    pending[$];   // requests accepted by memory, not yet answered
  out_txn_t    sb[$];        // expected FIFO contents, head first

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_req    = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  logic [31:0] next_req_pc = RESET_PC;
  bit          rst_q_m  = 1'b1;
  bit          armed    = 1'b0;
  out_txn_t    last_m   = '{32'h0, 32'h0};

  // Stimulus knobs (percentages and latency range).
  int          ready_pct = 100, oready_pct = 100, rsp_pct = 100, redir_pct = 0;
  int          min_lat = 1, max_lat = 1;
  bit          rst_cmd = 1'b1, redir_cmd = 1'b0;
  logic [31:0] redir_target = '0;

  function automatic logic [31:0] imem_word(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic pulse_reset();
    rst_cmd = 1'b1;
    tick(2);
    rst_cmd = 1'b0;
    tick(1);
  endtask

  task automatic wait_pending(input int n, input int budget);
    int k = 0;
    while (pending.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_pending", 32'(pending.size() >= n), 32'd1);
  endtask

  // Driver: all inputs change just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      rst            = rst_cmd;
      redirect_valid = 1'b0;
      if (redir_cmd) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_target;
        redir_cmd      = 1'b0;
      end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end
      imem_req_ready = ($urandom_range(99) < ready_pct);
      out_ready      = ($urandom_range(99) < oready_pct);
      if (pending.size() > 0 && pending[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pending[0].data;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Monitor and reference model: evaluated on the falling edge, where every
  // input for the coming rising edge is already stable.
  bit       exp_req;
  mem_txn_t p;
  out_txn_t t;

  always @(negedge clk) begin
    exp_req = !rst_q_m && (sb.size() + pending.size() < DEPTH) && !redirect_valid;
    if (armed) begin
      check("occupancy", 32'(occupancy), 32'(sb.size()));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req && imem_req_ready) check("req_addr", imem_req_addr, next_req_pc);
      if (sb.size() != 0) begin
        last_m = sb[0];
        if (out_ready) begin
          t = sb.pop_front();
          check("out_pc", out_pc, t.pc);
          check("out_instr", out_instr, t.instr);
        end
      end else begin
        check("hold_pc", out_pc, last_m.pc);
        check("hold_instr", out_instr, last_m.instr);
      end
    end

    if (imem_rsp_valid && pending.size() > 0) begin
      p = pending.pop_front();
      if (!redirect_valid && p.epoch == epoch) sb.push_back('{p.pc, p.data});
    end
    if (exp_req && imem_req_ready) begin
      p.pc    = next_req_pc;
      p.data  = imem_word(next_req_pc);
      p.epoch = epoch;
      p.due   = cyc + int'($urandom_range(max_lat, min_lat));
      pending.push_back(p);
      next_req_pc = next_req_pc + 32'd4;
      n_req++;
    end
    if (redirect_valid) begin
      sb.delete();
      epoch++;
      next_req_pc = redirect_pc & ~32'h3;
    end
    if (rst) begin
      sb.delete();
      pending.delete();
      epoch++;
      next_req_pc = RESET_PC;
      last_m      = '{32'h0, 32'h0};
      armed       = 1'b1;
    end
    rst_q_m = rst;
  end

  int n0;

  initial begin
    tick(3);
    rst_cmd = 1'b0;
    tick(1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);

    // Streaming: always-ready memory, 1-cycle latency, decode always ready.
    tick(40);

    // Decode stall fills the FIFO exactly to DEPTH, then drains in order.
    pulse_reset();
    n0 = n_req;
    oready_pct = 0;
    tick(20);
    check("stall_occ", 32'(occupancy), 32'(DEPTH));
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_reqs", 32'(n_req - n0), 32'(DEPTH));
    oready_pct = 100;
    tick(30);

    // Redirect with three responses outstanding at 3-cycle latency.
    min_lat = 3; max_lat = 3;
    wait_pending(3, 50);
    redir_target = 32'h0000_0103;
    redir_cmd    = 1'b1;
    tick(1);
    check("redir_no_req", 32'(imem_req_valid), 32'd0);
    tick(40);

    // Redirect coinciding with a response and a pop.
    min_lat = 1; max_lat = 1;
    tick(6);
    redir_target = 32'h0000_2468;
    redir_cmd    = 1'b1;
    tick(1);
    check("redir2_no_req", 32'(imem_req_valid), 32'd0);
    tick(1);
    check("redir2_occ", 32'(occupancy), 32'd0);
    tick(20);

    // Reset in the middle of a flush.
    min_lat = 3; max_lat = 3;
    wait_pending(3, 50);
    rsp_pct      = 0;
    redir_target = 32'h0000_0800;
    redir_cmd    = 1'b1;
    tick(1);
    rsp_pct = 100;
    rst_cmd = 1'b1;
    tick(1);
    rst_cmd = 1'b0;
    tick(1);
    check("flush_rst_out_valid", 32'(out_valid), 32'd0);
    check("flush_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("flush_rst_occ", 32'(occupancy), 32'd0);
    check("flush_rst_pc", out_pc, 32'd0);
    tick(30);

    // Fetch address wraps at the top of the address space.
    min_lat = 1; max_lat = 1;
    redir_target = 32'hFFFF_FFF8;
    redir_cmd    = 1'b1;
    tick(25);

    // Fully random traffic with random redirects and occasional resets.
    ready_pct = 70; oready_pct = 70; rsp_pct = 70; redir_pct = 4;
    min_lat = 1; max_lat = 4;
    for (int i = 0; i < 4; i++) begin
      tick(700);
      if (i == 1) pulse_reset();
    end
    redir_pct = 0;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID register and drives the decode stage.
- Owns the fetch PC and issues in-order word requests to instruction memory.
- Buffers returned instructions with their PCs in a small FIFO.
- On a taken jump or branch from EX/MEM, flushes its FIFO and discards all in-flight responses.
- Replaces the free-running PC+4 register and absorbs decode stalls without re-fetching.

Parameters:
- DEPTH, 4, number of FIFO entries; also the maximum outstanding requests. Power of two, 2..16.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- redirect_valid  in  1  taken jump/branch this cycle.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and treated as 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  instruction returned, in request order.
- imem_rsp_data  in  32  returned instruction.
- out_valid  out  1  FIFO head valid.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC; the IF/ID stage derives PC+4 from this.
- out_ready  in  1  decode accepts the head (low while the pipeline is paused).
- occupancy  out  clog2(DEPTH)+1  number of valid FIFO entries.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; drop_cnt=0.
  - Outputs: out_valid=0, imem_req_valid=0, occupancy=0, out_instr=0, out_pc=0.
  - Reset has priority over every other input, including a redirect in the same cycle, and aborts all outstanding tracking mid-operation.
- Request issue:
  - imem_req_valid = !rst_q && (occupancy + inflight + drop_cnt < DEPTH) && !redirect_valid.
  - rst_q is rst registered; it holds issue off for the first cycle after reset.
  - imem_req_addr = fetch_pc.
  - On handshake (valid & ready): fetch_pc += 4 with 32-bit wrap (32'hFFFF_FFFC -> 0), inflight += 1, and the issued PC is pushed into an internal PC tag FIFO.
- Response:
  - A response with drop_cnt>0 decrements drop_cnt and is discarded.
  - Otherwise it pops the PC tag FIFO, pushes {tag PC, data} into the FIFO, and decrements inflight.
  - Credit accounting guarantees the FIFO never overflows.
  - A response arriving with inflight+drop_cnt=0 is a protocol error: it is ignored and asserts an SVA in simulation.
- Output:
  - out_valid = occupancy!=0; out_instr/out_pc come from the head entry.
  - Pop on out_valid & out_ready.
  - Push latency: a response written at edge N is visible at the head by cycle N+1 (empty FIFO).
  - Full: occupancy=DEPTH implies no new request, because of credit.
  - Empty: out_valid=0 and out_instr/out_pc hold their last values.
- Redirect (redirect_valid=1, rst=0), at the next edge:
  - FIFO and PC tag FIFO cleared; occupancy=0; fetch_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt = drop_cnt + inflight - (rsp_valid this cycle ? 1 : 0), saturating at 0; inflight=0.
  - No request is issued in the redirect cycle. A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle completes a handshake, but the consumer is flushed by the same redirect.
  - Back-to-back redirects: the last one wins, and drop_cnt accumulates correctly.
- Simultaneous push and pop: occupancy unchanged; ordering is preserved.
- State machine FLUSHING <-> RUN:
  - RUN: normal operation.
  - FLUSHING: entered on a redirect when the new drop_cnt>0. Requests are still allowed under credit.
  - Return to RUN when drop_cnt reaches 0.
  - The FSM state is an internal debug signal.

Optional Feature:
- IFQ_BYPASS_EN
- Defined: when the FIFO is empty and a non-dropped response arrives, out_valid=1 combinationally in that cycle, with out_instr=imem_rsp_data and out_pc=the tag-head PC.
  - If out_ready=1, the entry is consumed without being written. Otherwise it is written as normal.
  - Bypass is suppressed in a redirect cycle.
- Undefined: out_valid is purely registered; there is a minimum of 1 cycle from response to head.

Test Plan:
- Reset, RESET_PC=0, imem always ready with 1-cycle response latency, out_ready=1 -> requests to 0x0,0x4,0x8,... are issued back-to-back, out_pc sequence is 0x0,0x4,0x8 with matching data, and occupancy stays ≤1.
- out_ready=0 for 20 cycles with DEPTH=4 -> exactly 4 requests issued, occupancy=4, imem_req_valid=0. Release out_ready -> 4 pops in order, then fetch resumes at 0x10.
- Memory responds with 3-cycle latency, 3 requests outstanding, redirect_pc=0x103 -> the next 3 responses are discarded, the next request address is 0x100, and out_pc is 0x100 first.
- Redirect asserted in the same cycle as a response and as a pop -> response dropped, drop_cnt=inflight-1, occupancy=0 next cycle, no request issued that cycle.
- rst=1 asserted mid-flush with drop_cnt=2 -> next cycle all outputs are at reset values and drop_cnt=0. The first post-reset request is to RESET_PC; late stale responses trigger only the SVA.
- fetch_pc=0xFFFF_FFF8 with two requests accepted -> addresses 0xFFFF_FFF8 then 0xFFFF_FFFC, and the next request is to 0x0000_0000.
